// File: rtl/spi_mstr_ctrl_pkg.sv
// Shared types and helpers for the spi_mstr_ctrl SPI master.
package spi_mstr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int HALF_PER_WORD  = 2 * DEF_DATA_WIDTH;

  // sck half-periods spent in SHIFT for one word of dw bits
  function automatic int half_periods(input int dw);
    return 2 * dw;
  endfunction

  // width of a down-counter that must hold clk_div-1 (at least one bit)
  function automatic int div_cnt_w(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/spi_mstr_ctrl_tick.sv
// Half-period timer: reloads CLK_DIV-1 on load or on reaching zero; tick while at zero.
module spi_mstr_ctrl_tick
  import spi_mstr_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = div_cnt_w(CLK_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // free-running between loads so every half-period is exactly CLK_DIV cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= RELOAD;
    end else if (load || (cnt == {CNT_W{1'b0}})) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - ONE;
    end
  end

  assign tick = (cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/spi_mstr_ctrl.sv
// SPI master: valid/ready word stream to sck/mosi/ss frames, miso word back on rx.
// Optional macro SPI_MSTR_CTRL_LSB_FIRST_EN selects LSB-first bit order (default MSB first).
module spi_mstr_ctrl
  import spi_mstr_ctrl_pkg::*;
#(
  parameter int SS_WIDTH   = 1,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [SS_WIDTH-1:0]   tx_ss_sel,
  input  logic                  tx_last,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic [SS_WIDTH-1:0]   ss
);

  localparam int               HPW     = half_periods(DATA_WIDTH);
  localparam int               HPW_W   = $clog2(HPW);
  localparam logic [HPW_W-1:0] HP_LAST = HPW_W'(HPW - 1);
  localparam logic [HPW_W-1:0] HP_ONE  = HPW_W'(1);
  localparam logic             CPOL_B  = 1'(CPOL);
  localparam logic             CPHA_B  = 1'(CPHA);

`ifdef SPI_MSTR_CTRL_LSB_FIRST_EN
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return w[0];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return {1'b0, w[DATA_WIDTH-1:1]};
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w, input logic b);
    return {b, w[DATA_WIDTH-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return {w[DATA_WIDTH-2:0], 1'b0};
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w, input logic b);
    return {w[DATA_WIDTH-2:0], b};
  endfunction
`endif

  state_e                state;
  state_e                state_nxt;
  logic                  tick;
  logic                  tick_load;
  logic [HPW_W-1:0]      hp_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  last_word;
  logic [SS_WIDTH-1:0]   sel;

  spi_mstr_ctrl_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .load  (tick_load),
    .tick  (tick)
  );

  assign tx_ready = (state == ST_IDLE) || (state == ST_WAIT);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state; the half-period timer is restarted on every word accept
  always_comb begin
    state_nxt = state;
    tick_load = 1'b0;
    case (state)
      ST_IDLE, ST_WAIT: begin
        if (tx_valid) begin
          state_nxt = ST_SETUP;
          tick_load = 1'b1;
        end else begin
          state_nxt = state;
        end
      end
      ST_SETUP: begin
        if (tick) state_nxt = ST_SHIFT;
        else      state_nxt = state;
      end
      ST_SHIFT: begin
        if (tick && (hp_cnt == HP_LAST)) state_nxt = ST_HOLD;
        else                             state_nxt = state;
      end
      ST_HOLD: begin
        if (tick) state_nxt = last_word ? ST_GAP : ST_WAIT;
        else      state_nxt = state;
      end
      ST_GAP: begin
        if (tick) state_nxt = ST_IDLE;
        else      state_nxt = state;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // serial datapath and SPI pins
  always_ff @(posedge clk) begin
    if (reset) begin
      sck       <= CPOL_B;
      mosi      <= 1'b0;
      ss        <= {SS_WIDTH{1'b1}};
      rx_valid  <= 1'b0;
      rx_data   <= {DATA_WIDTH{1'b0}};
      hp_cnt    <= {HPW_W{1'b0}};
      tx_sh     <= {DATA_WIDTH{1'b0}};
      rx_sh     <= {DATA_WIDTH{1'b0}};
      last_word <= 1'b0;
      sel       <= {SS_WIDTH{1'b0}};
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (tx_valid) begin
            // CPHA=0 presents the first bit during SETUP; CPHA=1 drives it on the first leading edge
            tx_sh     <= CPHA_B ? tx_data : shift_out(tx_data);
            mosi      <= CPHA_B ? 1'b0 : first_bit(tx_data);
            last_word <= tx_last;
            hp_cnt    <= {HPW_W{1'b0}};
            if (state == ST_IDLE) begin
              sel <= tx_ss_sel;
              ss  <= ~tx_ss_sel;
            end
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            sck    <= ~sck;
            hp_cnt <= hp_cnt + HP_ONE;
            // even hp_cnt produces a leading edge, odd a trailing edge
            if (hp_cnt[0] == CPHA_B) begin
              rx_sh <= shift_in(rx_sh, miso);
            end else if (hp_cnt != HP_LAST) begin
              mosi  <= first_bit(tx_sh);
              tx_sh <= shift_out(tx_sh);
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_sh;
            if (last_word) ss <= {SS_WIDTH{1'b1}};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mstr_ctrl.sv
// Scoreboard bench: mode-0 and mode-3 masters share one random stimulus stream, each with its own slave model.
module tb_spi_mstr_ctrl;

  localparam int DW      = 8;
  localparam int CLK_DIV = 2;
  localparam int SSW     = 2;
  localparam int NINST   = 2;
  localparam int NWORDS  = 128;

  typedef struct packed {
    logic [DW-1:0]  tx;
    logic [DW-1:0]  rx;
    logic [SSW-1:0] ss;
  } exp_t;

  logic           clk       = 1'b0;
  logic           reset     = 1'b1;
  logic           tx_valid  = 1'b0;
  logic           tx_last   = 1'b0;
  logic [DW-1:0]  tx_data   = '0;
  logic [SSW-1:0] tx_ss_sel = '0;

  logic [NINST-1:0] tx_ready_w, rx_valid_w, busy_w, sck_w, mosi_w;
  logic [DW-1:0]    rx_data_w [NINST];
  logic [SSW-1:0]   ss_w      [NINST];

  logic [DW-1:0]  slv_words [NWORDS];
  exp_t           exp_q [NINST][$];
  int             n_cmp   = 0;
  int             n_bad   = 0;
  int             acc_cnt = 0;
  logic           in_burst  = 1'b0;
  logic [SSW-1:0] burst_sel = '0;

  always #5 clk = ~clk;

  // j-th transmitted/received bit of a word and the rx_data index it lands in
  function automatic int bidx(input int j);
`ifdef SPI_MSTR_CTRL_LSB_FIRST_EN
    return j;
`else
    return DW - 1 - j;
`endif
  endfunction

  function automatic logic obit(input logic [DW-1:0] w, input int j);
    return w[bidx(j)];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < NINST; g++) begin : g_inst
    // instance 0: CPOL=0/CPHA=0, instance 1: CPOL=1/CPHA=1
    logic           miso      = 1'b0;
    int             edge_n    = 0;
    int             word_n    = 0;
    logic [DW-1:0]  cap       = '0;
    logic [DW-1:0]  mosi_word = '0;
    logic [SSW-1:0] ss_cap    = '0;
    logic [SSW-1:0] ss_word   = '0;
    exp_t           e;

    spi_mstr_ctrl #(
      .SS_WIDTH(SSW), .DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .CPOL(g), .CPHA(g)
    ) u_dut (
      .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready_w[g]),
      .tx_data(tx_data), .tx_ss_sel(tx_ss_sel), .tx_last(tx_last),
      .rx_valid(rx_valid_w[g]), .rx_data(rx_data_w[g]), .busy(busy_w[g]),
      .sck(sck_w[g]), .mosi(mosi_w[g]), .miso(miso), .ss(ss_w[g])
    );

    // slave: counts sck edges per word, samples mosi and drives miso per its SPI mode
    always @(sck_w[g] or posedge reset) begin
      if (reset) begin
        edge_n = 0;
        word_n = acc_cnt;
        miso   = (g == 0) ? obit(slv_words[word_n % NWORDS], 0) : 1'b0;
      end else begin
        if (edge_n == 0) ss_cap = ss_w[g];
        if ((edge_n % 2) == g) cap[bidx(edge_n / 2)] = mosi_w[g];
        else if (g == 1) miso = obit(slv_words[word_n % NWORDS], edge_n / 2);
        else if (edge_n < 2 * DW - 1) miso = obit(slv_words[word_n % NWORDS], (edge_n + 1) / 2);
        edge_n++;
        if (edge_n == 2 * DW) begin
          edge_n    = 0;
          mosi_word = cap;
          ss_word   = ss_cap;
          word_n++;
          if (g == 0) miso = obit(slv_words[word_n % NWORDS], 0);
        end
      end
    end

    // monitor: every rx_valid retires the oldest expected word
    always @(negedge clk) begin
      if (!reset && rx_valid_w[g]) begin
        chk($sformatf("i%0d rx_valid has pending word", g), 32'(exp_q[g].size() > 0), 32'd1);
        if (exp_q[g].size() > 0) begin
          e = exp_q[g].pop_front();
          chk($sformatf("i%0d rx_data", g), 32'(rx_data_w[g]), 32'(e.rx));
          chk($sformatf("i%0d mosi word", g), 32'(mosi_word), 32'(e.tx));
          chk($sformatf("i%0d ss during word", g), 32'(ss_word), 32'(e.ss));
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic l, input logic [SSW-1:0] s);
    int   t = 0;
    exp_t e;
    tx_data = d; tx_last = l; tx_ss_sel = s; tx_valid = 1'b1;
    while (tx_ready_w[0] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("accept within bound", 32'(t < 1000), 32'd1);
    if (!in_burst) burst_sel = s;
    e.tx = d;
    e.rx = slv_words[acc_cnt % NWORDS];
    e.ss = ~burst_sel;
    in_burst = !l;
    for (int g = 0; g < NINST; g++) exp_q[g].push_back(e);
    acc_cnt++;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_w != '0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("idle within bound", 32'(t < 5000), 32'd1);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (tx_ready_w[0] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("ready within bound", 32'(t < 1000), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lo, hi, bad;
    logic l;
    for (int i = 0; i < NWORDS; i++) slv_words[i] = DW'($urandom);
    slv_words[0] = 8'h3C;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NINST; g++) begin
      chk("reset sck", 32'(sck_w[g]), 32'(g[0]));
      chk("reset mosi", 32'(mosi_w[g]), 32'd0);
      chk("reset ss", 32'(ss_w[g]), 32'h3);
      chk("reset rx_valid", 32'(rx_valid_w[g]), 32'd0);
      chk("reset rx_data", 32'(rx_data_w[g]), 32'd0);
      chk("reset busy", 32'(busy_w[g]), 32'd0);
      chk("reset tx_ready", 32'(tx_ready_w[g]), 32'd1);
    end

    // single word: ss low length and gap before ready
    send(8'hA5, 1'b1, 2'b01);
    lo = 0;
    while (ss_w[0] != 2'b11 && lo < 200) begin lo++; @(negedge clk); end
    chk("ss low cycles", 32'(lo), 32'(CLK_DIV * (2 * DW + 2)));
    hi = 0;
    while (tx_ready_w[0] !== 1'b1 && hi < 200) begin hi++; @(negedge clk); end
    chk("gap cycles", 32'(hi), 32'(CLK_DIV));

    // burst: ss must not rise between words
    send(8'h11, 1'b0, 2'b11);
    hi = 0;
    for (int t = 0; tx_ready_w[0] !== 1'b1 && t < 500; t++) begin
      if (ss_w[0] == 2'b11 || ss_w[1] == 2'b11) hi++;
      @(negedge clk);
    end
    chk("burst ss high cycles", 32'(hi), 32'd0);
    send(8'h22, 1'b1, 2'b11);
    wait_idle();

    // WAIT stall, then later words try another select
    send(8'h33, 1'b0, 2'b10);
    wait_ready();
    bad = 0;
    repeat (10) begin
      for (int g = 0; g < NINST; g++)
        if (ss_w[g] != 2'b01 || sck_w[g] != g[0] || tx_ready_w[g] != 1'b1) bad++;
      @(negedge clk);
    end
    chk("wait stall bad cycles", 32'(bad), 32'd0);
    send(8'h44, 1'b0, 2'b01);
    send(8'h55, 1'b1, 2'b01);
    wait_idle();
    send(8'h66, 1'b1, 2'b00);
    wait_idle();

    // random traffic
    for (int i = 0; i < 40; i++) begin
      l = (i == 39) ? 1'b1 : ($urandom_range(0, 2) == 0);
      send(DW'($urandom), l, SSW'($urandom));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    wait_idle();

    // reset during SHIFT, with tx_valid high while reset is asserted
    send(8'h5A, 1'b1, 2'b11);
    repeat (16) @(negedge clk);
    reset = 1'b1; tx_valid = 1'b1; tx_data = DW'($urandom); tx_last = 1'b1;
    in_burst = 1'b0;
    for (int g = 0; g < NINST; g++) exp_q[g].delete();
    @(negedge clk);
    for (int g = 0; g < NINST; g++) begin
      chk("mid reset ss", 32'(ss_w[g]), 32'h3);
      chk("mid reset sck", 32'(sck_w[g]), 32'(g[0]));
      chk("mid reset mosi", 32'(mosi_w[g]), 32'd0);
      chk("mid reset rx_valid", 32'(rx_valid_w[g]), 32'd0);
      chk("mid reset tx_ready", 32'(tx_ready_w[g]), 32'd1);
    end
    @(negedge clk);
    reset = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NINST; g++) chk("reset beats tx_valid", 32'(busy_w[g]), 32'd0);
    send(8'hC3, 1'b1, 2'b01);
    wait_idle();
    repeat (4) @(negedge clk);
    for (int g = 0; g < NINST; g++) chk("scoreboard drained", 32'(exp_q[g].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_mstr_ctrl.md
Name: spi_mstr_ctrl

Overview:
- RTL SPI master that converts a valid/ready word stream into SPI frames on sck/mosi/ss and returns the miso word.
- Sits directly upstream of the SPI interface: it is the DUT-side master that drives sck, mosi and ss, and samples miso.
- Supports multi-word bursts with ss held low, and compile-time SPI mode (CPOL/CPHA).

Parameters:
- SS_WIDTH, 1, number of slave-select lines.
- DATA_WIDTH, 8, bits per word.
- CLK_DIV, 2, sck half-period in clk cycles (>=1).
- CPOL, 0, sck idle level.
- CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tx_valid  in  1  word offered.
- tx_ready  out  1  word accepted when tx_valid && tx_ready.
- tx_data  in  DATA_WIDTH  word to shift out.
- tx_ss_sel  in  SS_WIDTH  one-hot-or-multi select mask, active-high.
- tx_last  in  1  1 = release ss after this word.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- rx_data  out  DATA_WIDTH  received word.
- busy  out  1  ss asserted or GAP in progress.
- sck  out  1  SPI clock.
- mosi  out  1  master out.
- miso  in  1  master in.
- ss  out  SS_WIDTH  active-low selects.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, sck=CPOL, mosi=0, ss=all ones, rx_valid=0, rx_data=0, busy=0. tx_ready is decoded from state, so it is 1 in the first cycle after reset.
- Half-period tick: counter reloads CLK_DIV-1 on entry to every timed state; tick when it reaches 0.
- States: IDLE, SETUP, SHIFT, HOLD, WAIT, GAP.
- tx_ready=1 only in IDLE and WAIT.
- IDLE: on accept, latch tx_data, tx_last and tx_ss_sel. Go to SETUP next cycle, with ss=~sel registered on that edge.
- SETUP: one half-period. For CPHA=0, mosi carries bit 0 of the shift order.
- SHIFT: 2*DATA_WIDTH half-periods. sck toggles on each tick edge.
  - Leading edge = sck leaving CPOL. Trailing edge = sck returning to CPOL.
  - miso is sampled on the clk edge that produces the sampling sck edge.
  - mosi is updated on the clk edge that produces the opposite sck edge.
  - CPHA=1: first mosi drive is on the first leading edge.
- HOLD: one half-period with sck=CPOL. At HOLD end: rx_valid pulses for exactly 1 cycle and rx_data gets the shifted word.
  - tx_last=1: go to GAP.
  - tx_last=0: go to WAIT.
- WAIT: ss stays low, sck=CPOL, and the state is held indefinitely.
  - On accept, go to SETUP. The new tx_data and tx_last are latched; tx_ss_sel is ignored and the burst keeps its original selects.
- GAP: ss=all ones for one half-period, then IDLE.
- Frame timing: ss low from SETUP entry to HOLD exit = CLK_DIV*(2*DATA_WIDTH+2) cycles per word.
- busy=1 in every state except IDLE.
- tx_ss_sel=0: the frame runs normally with ss all ones.
- rx has no backpressure. rx_data holds its value until the next rx_valid.
- Reset mid-frame: next edge returns to the reset values, with no rx_valid and no partial word.
- Reset with simultaneous tx_valid: reset wins and the word is not accepted.

Optional Feature:
- Macro: SPI_MSTR_CTRL_LSB_FIRST_EN.
- Defined: bit 0 is transmitted first and the first received bit lands in rx_data[0].
- Undefined (default): MSB first, and the first received bit lands in rx_data[DATA_WIDTH-1].

Decomposition:
- Package spi_mstr_ctrl_pkg contains:
  - the state enum;
  - function clog2-based div counter width;
  - localparam for half-periods per word (2*DATA_WIDTH).
- One sub-module: spi_mstr_ctrl_tick, the half-period counter with load/tick.

Test Plan:
- Mode 0, CLK_DIV=2, tx 0xA5 last=1, slave model returns 0x3C → mosi bits 1,0,1,0,0,1,0,1; rx_data=0x3C with one rx_valid; ss low 36 cycles, then high 2 cycles before tx_ready.
- Burst: 0x11 last=0, then 0x22 last=1 → ss continuously low; two rx_valid pulses; no GAP between words.
- Mode 3 (CPOL=1, CPHA=1), tx 0xF0 → sck idles 1; miso sampled on rising sck; rx matches slave 0x0F.
- WAIT stall: last=0, then tx_valid withheld 10 cycles → ss stays low, sck=CPOL, tx_ready=1 throughout.
- SS_WIDTH=2, tx_ss_sel=2'b10 → ss=2'b01 during the frame. A second burst word with sel=2'b01 is ignored: ss stays 2'b01.
- reset asserted during bit 3 of SHIFT → next cycle ss=2'b11, sck=CPOL, mosi=0, no rx_valid, tx_ready=1.
